// File: rtl/vga_glyph_reader.sv
// Glyph row fetcher and pixel serializer for a character-cell VGA path.
// A request {char, row} is registered as the font address; the font row
// returns two edges later, is optionally inverted, and is shifted out
// leftmost pixel first over 8 cycles. A new request can be taken while
// pixel 5 is on the output so the next row lands exactly as pixel 7 ends.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | shifter empty, pixel_valid_o low
// ST_SHIFT | shifter holds a row, cnt_q is the pixel index on pixel_o
module vga_glyph_reader #(
  parameter int CHAR_W = 8,
  parameter int ROW_W  = 3
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [CHAR_W-1:0]       char_i,
  input  logic [ROW_W-1:0]        row_i,
  input  logic                    inv_i,
  output logic [CHAR_W+ROW_W-1:0] font_addr_o,
  input  logic [0:7]              font_data_i,
  output logic                    pixel_o,
  output logic                    pixel_valid_o,
  output logic                    cell_done_o
);

  localparam int AW = CHAR_W + ROW_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [0:7]    sh_q, sh_d;
  logic          f1_q, f1_d;
  logic          f2_q, f2_d;
  logic          inv_q, inv_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          accept;

  // Ready only with no fetch in flight, and either empty or at the slot
  // whose two-edge fetch latency ends exactly at the last pixel.
  always_comb begin
    req_ready_o = !f1_q && !f2_q && ((state_q == ST_IDLE) || (cnt_q == 3'd5));
    accept      = req_valid_i && req_ready_o;
  end

  // Next-state: fetch pipeline flags, address/inv capture, shifter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    inv_d   = inv_q;
    f1_d    = accept;
    f2_d    = f1_q;
    if (accept) begin
      addr_d = {char_i, row_i};
      inv_d  = inv_i;
    end
    if (f2_q) begin
      sh_d    = font_data_i ^ {8{inv_q}};
      state_d = ST_SHIFT;
      cnt_d   = 3'd0;
    end else if (state_q == ST_SHIFT) begin
      sh_d = {sh_q[1:7], 1'b0};
      if (cnt_q == 3'd7) begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // State registers; reset aborts any fetch or cell in progress.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= '0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      inv_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      inv_q   <= inv_d;
      addr_q  <= addr_d;
    end
  end

  // Output decode; pixel is forced low when the shifter is empty.
  always_comb begin
    font_addr_o   = addr_q;
    pixel_valid_o = (state_q == ST_SHIFT);
    pixel_o       = pixel_valid_o && sh_q[0];
    cell_done_o   = pixel_valid_o && (cnt_q == 3'd7);
  end

endmodule
